// File: rtl/crc_check_unit.sv
// Streaming CRC checker: accumulates a configurable CRC over a word stream,
// compares it with a received hash per frame and keeps saturating status counters.
module crc_check_unit #(
    parameter int                 CRC_W  = 16,
    parameter logic [CRC_W-1:0]   POLY   = 16'h1021,
    parameter logic [CRC_W-1:0]   INIT   = 16'hFFFF,
    parameter int                 DATA_W = 8,
    parameter int                 CNT_W  = 8
) (
    input  logic              clk50m,
    input  logic              rst_n,
    input  logic              frame_start,
    input  logic              data_valid,
    input  logic [DATA_W-1:0] data_in,
    input  logic              hash_valid,
    input  logic [CRC_W-1:0]  crc_hash,
    input  logic              clr_cnt,
    output logic              busy,
    output logic [CRC_W-1:0]  crc_calc,
    output logic              crc_done,
    output logic              crc_ok,
    output logic              crc_err,
    output logic [CNT_W-1:0]  frame_cnt,
    output logic [CNT_W-1:0]  err_cnt
);

    typedef enum logic {IDLE = 1'b0, ACCU = 1'b1} state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t             state_q, state_d;
    logic [CRC_W-1:0]   crc_calc_q, crc_calc_d;
    logic               crc_done_q, crc_done_d;
    logic               crc_ok_q, crc_ok_d;
    logic               crc_err_q, crc_err_d;
    logic [CNT_W-1:0]   frame_cnt_q, frame_cnt_d;
    logic [CNT_W-1:0]   err_cnt_q, err_cnt_d;
    logic [CRC_W-1:0]   crc_next;
    logic               match;

    // One word folded in MSB first, all DATA_W shift steps unrolled into one cycle.
    function automatic logic [CRC_W-1:0] crc_update(input logic [CRC_W-1:0] crc_in,
                                                    input logic [DATA_W-1:0] d);
        logic [CRC_W-1:0] c;
        logic             fb;
        c = crc_in;
        for (int i = DATA_W - 1; i >= 0; i--) begin
            fb = c[CRC_W-1] ^ d[i];
            c  = {c[CRC_W-2:0], 1'b0} ^ (fb ? POLY : '0);
        end
        return c;
    endfunction

    always_comb begin
        crc_next    = data_valid ? crc_update(crc_calc_q, data_in) : crc_calc_q;
        match       = (crc_next == crc_hash);
        state_d     = state_q;
        crc_calc_d  = crc_calc_q;
        crc_done_d  = 1'b0;
        crc_ok_d    = crc_ok_q;
        crc_err_d   = crc_err_q;
        frame_cnt_d = frame_cnt_q;
        err_cnt_d   = err_cnt_q;

        if (frame_start) begin
            state_d    = ACCU;
            crc_calc_d = INIT;
            crc_ok_d   = 1'b0;
            crc_err_d  = 1'b0;
        end else if (state_q == ACCU) begin
            crc_calc_d = crc_next;
            if (hash_valid) begin
                state_d    = IDLE;
                crc_done_d = 1'b1;
                crc_ok_d   = match;
                crc_err_d  = !match;
                if (frame_cnt_q != CNT_MAX) frame_cnt_d = frame_cnt_q + 1'b1;
                if (!match && err_cnt_q != CNT_MAX) err_cnt_d = err_cnt_q + 1'b1;
            end
        end

        // Clear wins over an increment landing in the same cycle.
        if (clr_cnt) begin
            frame_cnt_d = '0;
            err_cnt_d   = '0;
        end
    end

    always_ff @(posedge clk50m or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            crc_calc_q  <= INIT;
            crc_done_q  <= 1'b0;
            crc_ok_q    <= 1'b0;
            crc_err_q   <= 1'b0;
            frame_cnt_q <= '0;
            err_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            crc_calc_q  <= crc_calc_d;
            crc_done_q  <= crc_done_d;
            crc_ok_q    <= crc_ok_d;
            crc_err_q   <= crc_err_d;
            frame_cnt_q <= frame_cnt_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign busy      = (state_q == ACCU);
    assign crc_calc  = crc_calc_q;
    assign crc_done  = crc_done_q;
    assign crc_ok    = crc_ok_q;
    assign crc_err   = crc_err_q;
    assign frame_cnt = frame_cnt_q;
    assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_crc_check_unit.sv
// Bench for crc_check_unit: a default CRC-16 instance and a CRC-32/2-bit-counter
// instance share one stimulus stream; a polynomial long-division model predicts results.
module tb_crc_check_unit;

    logic        clk50m = 1'b0;
    logic        rst_n = 1'b0;
    logic        frame_start = 1'b0, data_valid = 1'b0, hash_valid = 1'b0, clr_cnt = 1'b0;
    logic [7:0]  data_in = '0;
    logic [31:0] crc_hash = '0;

    logic        a_busy, a_done, a_ok, a_err;
    logic [15:0] a_crc;
    logic [7:0]  a_fc, a_ec;
    logic        b_busy, b_done, b_ok, b_err;
    logic [31:0] b_crc;
    logic [1:0]  b_fc, b_ec;

    always #10 clk50m = ~clk50m;

    crc_check_unit dut_a (
        .clk50m(clk50m), .rst_n(rst_n), .frame_start(frame_start), .data_valid(data_valid),
        .data_in(data_in), .hash_valid(hash_valid), .crc_hash(crc_hash[15:0]), .clr_cnt(clr_cnt),
        .busy(a_busy), .crc_calc(a_crc), .crc_done(a_done), .crc_ok(a_ok), .crc_err(a_err),
        .frame_cnt(a_fc), .err_cnt(a_ec)
    );

    crc_check_unit #(
        .CRC_W(32), .POLY(32'h04C11DB7), .INIT(32'hFFFFFFFF), .DATA_W(8), .CNT_W(2)
    ) dut_b (
        .clk50m(clk50m), .rst_n(rst_n), .frame_start(frame_start), .data_valid(data_valid),
        .data_in(data_in), .hash_valid(hash_valid), .crc_hash(crc_hash), .clr_cnt(clr_cnt),
        .busy(b_busy), .crc_calc(b_crc), .crc_done(b_done), .crc_ok(b_ok), .crc_err(b_err),
        .frame_cnt(b_fc), .err_cnt(b_ec)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state
    logic [7:0]  m_q[$];
    logic [7:0]  tx[$];
    bit          m_open = 0;
    int          a_fc_m = 0, a_ec_m = 0, b_fc_m = 0, b_ec_m = 0;
    logic [48:0] exp_a_q[$];
    logic [48:0] exp_b_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Register value = (INIT*x^n + M*x^W) mod P, found by long division of a bit string.
    function automatic logic [31:0] ref_crc(input int w, input logic [31:0] poly,
                                            input logic [31:0] init);
        bit b[$];
        logic [31:0] r;
        foreach (m_q[k]) for (int j = 7; j >= 0; j--) b.push_back(m_q[k][j]);
        for (int j = 0; j < w; j++) b.push_back(1'b0);
        for (int j = 0; j < w; j++) b[j] = b[j] ^ init[w-1-j];
        for (int i = 0; i < b.size() - w; i++)
            if (b[i]) for (int j = 0; j < w; j++) b[i+1+j] = b[i+1+j] ^ poly[w-1-j];
        r = '0;
        for (int j = 0; j < w; j++) r = (r << 1) | 32'(b[b.size()-w+j]);
        return r;
    endfunction

    function automatic logic [31:0] ref16();
        return ref_crc(16, 32'h1021, 32'hFFFF);
    endfunction

    function automatic logic [31:0] ref32();
        return ref_crc(32, 32'h04C11DB7, 32'hFFFFFFFF);
    endfunction

    function automatic int sat_inc(input int v, input int max);
        return (v < max) ? v + 1 : v;
    endfunction

    // One clock of stimulus; the model consumes the same inputs at issue time.
    task automatic drive(input bit fs, input bit dv, input logic [7:0] d,
                         input bit hv, input logic [31:0] h, input bit clr);
        logic [31:0] c16, c32;
        bit ok_a, ok_b;
        frame_start = fs; data_valid = dv; data_in = d; hash_valid = hv;
        crc_hash = h; clr_cnt = clr;
        if (fs) begin
            m_open = 1;
            m_q.delete();
        end else if (m_open) begin
            if (dv) m_q.push_back(d);
            if (hv) begin
                c16 = ref16();
                c32 = ref32();
                ok_a = (c16[15:0] == h[15:0]);
                ok_b = (c32 == h);
                a_fc_m = sat_inc(a_fc_m, 255);
                b_fc_m = sat_inc(b_fc_m, 3);
                if (!ok_a) a_ec_m = sat_inc(a_ec_m, 255);
                if (!ok_b) b_ec_m = sat_inc(b_ec_m, 3);
                if (clr) begin a_fc_m = 0; a_ec_m = 0; b_fc_m = 0; b_ec_m = 0; end
                exp_a_q.push_back({ok_a, c16, 8'(a_fc_m), 8'(a_ec_m)});
                exp_b_q.push_back({ok_b, c32, 8'(b_fc_m), 8'(b_ec_m)});
                m_open = 0;
            end
        end
        if (clr) begin a_fc_m = 0; a_ec_m = 0; b_fc_m = 0; b_ec_m = 0; end
        @(posedge clk50m);
        #1;
        frame_start = 0; data_valid = 0; hash_valid = 0; clr_cnt = 0;
    endtask

    task automatic idle();
        drive(0, 0, 8'h00, 0, 32'h0, 0);
    endtask

    // frame_start, tx words, then hash (optionally with the final word in the same cycle)
    task automatic send_frame(input logic [31:0] h, input bit last_with_hash);
        int n;
        n = tx.size();
        drive(1, 0, 8'h00, 0, 32'h0, 0);
        check("busy_after_start", {31'b0, a_busy}, 1);
        for (int i = 0; i < n; i++)
            if (!(last_with_hash && i == n - 1)) drive(0, 1, tx[i], 0, 32'h0, 0);
        if (last_with_hash && n > 0) drive(0, 1, tx[n-1], 1, h, 0);
        else drive(0, 0, 8'h00, 1, h, 0);
        check("done_latency_a", {31'b0, a_done}, 1);
        check("done_latency_b", {31'b0, b_done}, 1);
        check("busy_falls", {31'b0, a_busy | b_busy}, 0);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_busy"}, {30'b0, a_busy, b_busy}, 0);
        check({tag, "_crc_a"}, {16'b0, a_crc}, 32'hFFFF);
        check({tag, "_crc_b"}, b_crc, 32'hFFFFFFFF);
        check({tag, "_flags"}, {26'b0, a_done, a_ok, a_err, b_done, b_ok, b_err}, 0);
        check({tag, "_cnts"}, {12'b0, a_fc, a_ec, b_fc, b_ec}, 0);
    endtask

    task automatic model_reset();
        m_open = 0; m_q.delete();
        a_fc_m = 0; a_ec_m = 0; b_fc_m = 0; b_ec_m = 0;
    endtask

    // Scoreboard monitor: pops one expectation per crc_done pulse.
    always @(negedge clk50m) begin
        logic [48:0] e;
        if (rst_n) begin
            check("a_ok_err_excl", {31'b0, a_ok & a_err}, 0);
            check("b_ok_err_excl", {31'b0, b_ok & b_err}, 0);
            if (a_done) begin
                if (exp_a_q.size() == 0) check("a_done_unexpected", 1, 0);
                else begin
                    e = exp_a_q.pop_front();
                    check("a_ok", {31'b0, a_ok}, {31'b0, e[48]});
                    check("a_err", {31'b0, a_err}, {31'b0, !e[48]});
                    check("a_crc", {16'b0, a_crc}, e[47:16]);
                    check("a_frame_cnt", {24'b0, a_fc}, {24'b0, e[15:8]});
                    check("a_err_cnt", {24'b0, a_ec}, {24'b0, e[7:0]});
                end
            end
            if (b_done) begin
                if (exp_b_q.size() == 0) check("b_done_unexpected", 1, 0);
                else begin
                    e = exp_b_q.pop_front();
                    check("b_ok", {31'b0, b_ok}, {31'b0, e[48]});
                    check("b_err", {31'b0, b_err}, {31'b0, !e[48]});
                    check("b_crc", b_crc, e[47:16]);
                    check("b_frame_cnt", {30'b0, b_fc}, {24'b0, e[15:8]});
                    check("b_err_cnt", {30'b0, b_ec}, {24'b0, e[7:0]});
                end
            end
        end
    end

    initial begin
        logic [31:0] h;
        int len, sel;
        bit lwh;
        repeat (2) @(posedge clk50m);
        #1 rst_n = 1;
        check_reset_values("reset");

        for (int i = 0; i < 9; i++) tx.push_back(8'(8'h31 + i));

        // Check string, good hash
        send_frame(32'h29B1, 0);
        check("std_crc16", {16'b0, a_crc}, 32'h29B1);
        check("std_ok", {30'b0, a_ok, a_err}, 2'b10);
        check("std_cnts", {16'b0, a_fc, a_ec}, {16'b0, 8'd1, 8'd0});

        // Bad hash, then frame_start clears the sticky error; empty frame follows
        send_frame(32'h29B0, 0);
        check("bad_flags", {30'b0, a_ok, a_err}, 2'b01);
        check("bad_err_cnt", {24'b0, a_ec}, 1);
        drive(1, 0, 8'h00, 0, 32'h0, 0);
        check("start_clears", {30'b0, a_ok, a_err}, 0);
        drive(0, 0, 8'h00, 1, 32'hFFFF, 0);
        check("empty_ok", {31'b0, a_ok}, 1);

        // Last word coincident with hash
        send_frame(32'h29B1, 1);
        check("last_with_hash_ok", {31'b0, a_ok}, 1);

        // CRC-32/MPEG-2
        send_frame(32'h0376E6E7, 0);
        check("crc32_value", b_crc, 32'h0376E6E7);
        check("crc32_ok", {31'b0, b_ok}, 1);

        // Back-to-back frame start right after hash
        drive(1, 0, 8'h00, 0, 32'h0, 0);
        check("b2b_clears", {30'b0, b_ok, b_err}, 0);

        // Reset mid-frame after 4 words
        for (int i = 0; i < 4; i++) drive(0, 1, tx[i], 0, 32'h0, 0);
        #3 rst_n = 0;
        #2 check_reset_values("async_reset");
        model_reset();
        @(posedge clk50m);
        #1 rst_n = 1;
        idle();
        check_reset_values("post_reset");

        // hash_valid while idle
        drive(0, 1, 8'h55, 1, 32'hFFFF, 0);
        check("idle_hash_no_done", {30'b0, a_done, b_done}, 0);
        idle();
        check_reset_values("idle_hash");

        // Five frames failing on the 32-bit instance: its 2-bit counters saturate
        for (int i = 0; i < 5; i++) send_frame(32'h29B1, 0);
        check("sat_b_err_cnt", {30'b0, b_ec}, 3);
        check("sat_b_frame_cnt", {30'b0, b_fc}, 3);
        check("sat_a_cnts", {16'b0, a_fc, a_ec}, {16'b0, 8'd5, 8'd0});

        // clr_cnt while crc_done is high, then clr_cnt in the hash cycle
        send_frame(32'h29B1, 0);
        drive(0, 0, 8'h00, 0, 32'h0, 1);
        check("clr_at_done", {12'b0, a_fc, a_ec, b_fc, b_ec}, 0);
        drive(1, 0, 8'h00, 0, 32'h0, 0);
        drive(0, 1, 8'h31, 0, 32'h0, 0);
        drive(0, 0, 8'h00, 1, 32'h1234, 1);
        check("clr_with_hash", {12'b0, a_fc, a_ec, b_fc, b_ec}, 0);

        // Randomized frames
        for (int f = 0; f < 60; f++) begin
            if ($urandom_range(0, 3) != 0) idle();
            drive(1, 0, 8'h00, 0, 32'h0, 0);
            len = $urandom_range(0, 12);
            for (int i = 0; i < len; i++) begin
                while ($urandom_range(0, 3) == 0)
                    drive(0, 0, 8'($urandom), $urandom_range(0, 7) == 0 ? 1'b0 : 1'b0,
                          32'h0, $urandom_range(0, 19) == 0);
                if ($urandom_range(0, 15) == 0) drive(1, 1, 8'($urandom), 1, $urandom, 0);
                if (i < len - 1 || $urandom_range(0, 2) != 0) drive(0, 1, 8'($urandom), 0, 32'h0, 0);
            end
            lwh = ($urandom_range(0, 2) == 0);
            data_in = 8'($urandom);
            if (lwh) m_q.push_back(data_in);
            sel = $urandom_range(0, 2);
            h = (sel == 0) ? {16'($urandom), ref16() & 32'hFFFF} :
                (sel == 1) ? ref32() : $urandom;
            if (sel == 0) h = h & 32'h0000FFFF;
            if (lwh) void'(m_q.pop_back());
            drive(0, lwh, data_in, 1, h, $urandom_range(0, 5) == 0);
        end
        idle();
        idle();
        check("final_a_cnts", {16'b0, a_fc, a_ec}, {16'b0, 8'(a_fc_m), 8'(a_ec_m)});
        check("final_b_cnts", {28'b0, b_fc, b_ec}, {28'b0, 2'(b_fc_m), 2'(b_ec_m)});
        check("a_queue_drained", exp_a_q.size(), 0);
        check("b_queue_drained", exp_b_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        n_bad++;
        $display("FAIL timeout: simulation exceeded time limit");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/crc_check_unit.md
# crc_check_unit

Parametrised streaming CRC checker for the CRC generation/check path. Accumulates a CRC over a data stream, one DATA_W-bit word per cycle. It compares the result against a received hash and reports ok/error per frame. It keeps saturating frame and error counters for status readout. It supersedes the fixed 16-bit compare stage by generating the CRC internally with configurable width, polynomial and init value.

## Interface
- CRC_W, 16: CRC width in bits (supported 8..32)
- POLY, 16'h1021: generator polynomial, implicit top bit omitted, CRC_W bits
- INIT, 16'hFFFF: CRC register preset at frame start, CRC_W bits
- DATA_W, 8: data word width (supported 1..32)
- CNT_W, 8: width of frame and error counters

- clk50m  in  1  system clock, all logic on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- frame_start  in  1  one-cycle pulse, begins a new frame
- data_valid  in  1  data_in valid this cycle
- data_in  in  DATA_W  payload word, MSB processed first
- hash_valid  in  1  one-cycle pulse, crc_hash valid, ends the frame
- crc_hash  in  CRC_W  received CRC
- clr_cnt  in  1  synchronous clear of both counters
- busy  out  1  high while a frame is open (state ACCU)
- crc_calc  out  CRC_W  current CRC register value
- crc_done  out  1  one-cycle pulse, compare result valid
- crc_ok  out  1  sticky: last frame matched
- crc_err  out  1  sticky: last frame mismatched
- frame_cnt  out  CNT_W  frames checked, saturating
- err_cnt  out  CNT_W  frames failed, saturating

## Operation
- CRC algorithm: non-reflected input and output, no final XOR.
- Per data word, CRC_W-bit register update runs DATA_W iterations, MSB of data_in first. Each iteration: fb = crc[CRC_W-1] ^ d; crc = (crc << 1) ^ (fb ? POLY : 0). All iterations complete in one cycle.
- FSM states:
  - IDLE to ACCU on frame_start.
  - ACCU to IDLE on hash_valid.
  - ACCU to ACCU on frame_start (restart).
- On frame_start, in any state:
  - crc_calc <= INIT
  - crc_ok <= 0, crc_err <= 0
  - state <= ACCU
- ACCU with data_valid: crc_calc <= update(crc_calc, data_in).
- ACCU with hash_valid:
  - Compare value is crc_calc, including a data_valid word in the same cycle (update first, then compare).
  - Next cycle: crc_done = 1, crc_ok = match, crc_err = !match.
  - crc_calc holds the final value.
- IDLE: data_valid and hash_valid are ignored, with no state or counter change.
- frame_start together with data_valid and/or hash_valid: frame_start wins. The other inputs are ignored that cycle.
- crc_ok and crc_err are never both 1. Both hold until the next frame_start or reset.
- Counters:
  - frame_cnt +1 on each crc_done; err_cnt +1 on each crc_done with mismatch.
  - Both saturate at 2^CNT_W-1.
  - clr_cnt zeroes both and takes priority over a same-cycle increment.

## Timing
- Reset values: state IDLE, busy 0, crc_calc INIT, crc_done 0, crc_ok 0, crc_err 0, frame_cnt 0, err_cnt 0.
- Reset asserted mid-frame aborts the frame immediately. No crc_done is produced.
- Data throughput: one word per cycle. crc_calc reflects word N one cycle after it is accepted.
- Latency: hash_valid at edge k gives crc_done, crc_ok/crc_err and the counter update at edge k+1.
- busy:
  - Rises the cycle after frame_start.
  - Falls the cycle after hash_valid, together with crc_done.
- Back-to-back frames: frame_start in the cycle right after hash_valid is legal. crc_done still pulses, then the new frame clears crc_ok/crc_err one cycle later.
- All outputs are registered.

## Test plan
- Default params, frame_start, then ASCII "123456789" (0x31..0x39, 9 words), hash_valid with 0x29B1 -> crc_calc 0x29B1, crc_done pulse at k+1, crc_ok 1, frame_cnt 1, err_cnt 0.
- Same frame with hash 0x29B0 -> crc_err 1, crc_ok 0, err_cnt 1; the next frame_start clears crc_err.
- Empty frame (frame_start, then hash_valid 0xFFFF) -> crc_ok 1. Last word "9" sent in the same cycle as hash_valid 0x29B1 -> crc_ok 1.
- Reset mid-frame after 4 words -> all outputs at reset values, no crc_done. A hash_valid in IDLE -> no response.
- CNT_W=2, 5 failing frames -> err_cnt saturates at 3. clr_cnt coincident with a crc_done -> both counters 0.
- CRC_W=32, POLY 32'h04C11DB7, INIT 32'hFFFFFFFF, "123456789" -> crc_calc 0x0376E6E7 (CRC-32/MPEG-2), crc_ok with a matching hash.
